// File: rtl/payload_engine_pkg.sv
// Payload engine shared types and widths.
// Index, vector and count sizes plus collector state.
package payload_engine_pkg;

  localparam int IDX_W = 5;
  localparam int VEC_W = 1 << IDX_W;
  localparam int CNT_W = $clog2(VEC_W + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    WAIT  = 1'b1
  } col_state_t;

endpackage

// File: rtl/idx_decode32.sv
// Index to one-hot decoder with enable.
// Shared by payload engine blocks.
module idx_decode32
  import payload_engine_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [VEC_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en)
      onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/index_collector32.sv
// Gathers serial match indices into a match vector.
// Accumulator and output register overlap packets.
module index_collector32
  import payload_engine_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ivld,
  input  logic [IDX_W-1:0] idx,
  input  logic             eop,
  output logic             irdy,
  output logic             dvld,
  output logic [VEC_W-1:0] dout,
  output logic [CNT_W-1:0] dcnt,
  input  logic             dack,
  output logic             ovf
);

  col_state_t       state;
  logic [VEC_W-1:0] acc;
  logic [CNT_W-1:0] acnt;
  logic [VEC_W-1:0] onehot;
  logic [VEC_W-1:0] vec;
  logic [CNT_W-1:0] cnt;
  logic             newbit;
  logic             out_free;

  idx_decode32 u_dec (
    .en     (ivld),
    .idx    (idx),
    .onehot (onehot)
  );

  always_comb begin
    vec      = acc | onehot;
    newbit   = |(onehot & ~acc);
    cnt      = acnt + CNT_W'(newbit);
    out_free = !dvld || dack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      acnt  <= '0;
      dout  <= '0;
      dcnt  <= '0;
      dvld  <= 1'b0;
      irdy  <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (dack)
            dvld <= 1'b0;
          if (eop && vec != '0) begin
            if (out_free) begin
              dout <= vec;
              dcnt <= cnt;
              dvld <= 1'b1;
              acc  <= '0;
              acnt <= '0;
            end else begin
              acc   <= vec;
              acnt  <= cnt;
              state <= WAIT;
              irdy  <= 1'b0;
            end
          end else if (!eop) begin
            acc  <= vec;
            acnt <= cnt;
          end
        end
        WAIT: begin
          // Inputs are dropped while the closed vector waits
          if (ivld || eop)
            ovf <= 1'b1;
          if (dack) begin
            dout  <= acc;
            dcnt  <= acnt;
            dvld  <= 1'b1;
            acc   <= '0;
            acnt  <= '0;
            state <= ACCUM;
            irdy  <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
